// File: rtl/a2d_sequencer.sv
// Periodic sweep scheduler for an 8-channel 12-bit A2D behind a 16-bit SPI monarch.
// Each enabled channel gets a command frame then a read frame; read results land in a small register file.
module a2d_sequencer #(
    parameter logic [15:0] PERIOD = 16'd5000,
    parameter int          CH_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2**CH_W-1:0]   chnl_mask,
    input  logic [CH_W-1:0]      rd_chnl,
    output logic [11:0]          rd_data,
    output logic                 sweep_done,
    output logic                 busy,
    output logic                 overrun,
    output logic                 spi_snd,
    output logic [15:0]          spi_cmd,
    input  logic                 spi_done,
    input  logic [15:0]          spi_resp
);
    localparam int NUM_CH = 2**CH_W;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SEND1,
        WAIT1,
        SEND2,
        WAIT2,
        WAIT_TMR
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CH_W-1:0]   ch_ptr_q;
    logic              exhausted_q;
    logic              stop_q;
    logic              pend_q;
    logic              done_prev_q;
    logic [15:0]       timer_q;
    logic              snd_q;
    logic [15:0]       cmd_q;
    logic              sweep_done_q;
    logic              busy_q;
    logic              overrun_q;
    logic [11:0]       result_q [NUM_CH];

    logic              found_d;
    logic [CH_W-1:0]   found_idx_d;
    logic              done_rise;
    logic              timer_expire;
    logic              sweep_start;

    // Upper response bits carry no conversion data.
    logic unused_resp_bits;
    assign unused_resp_bits = &{1'b0, spi_resp[15:12]};

    assign done_rise    = spi_done && !done_prev_q;
    assign timer_expire = en && (timer_q == PERIOD - 16'd1);
    assign sweep_start  = en && ((state_q == IDLE) ||
                                 ((state_q == WAIT_TMR) && (timer_expire || pend_q)));

    // Lowest enabled channel at or above the pointer; descending loop so the lowest hit wins.
    always_comb begin
        found_d     = 1'b0;
        found_idx_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(ch_ptr_q)) && !exhausted_q) begin
                found_d     = 1'b1;
                found_idx_d = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            ch_ptr_q     <= '0;
            exhausted_q  <= 1'b0;
            stop_q       <= 1'b0;
            pend_q       <= 1'b0;
            done_prev_q  <= 1'b0;
            timer_q      <= '0;
            snd_q        <= 1'b0;
            cmd_q        <= '0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            done_prev_q  <= spi_done;
            snd_q        <= 1'b0;
            sweep_done_q <= 1'b0;

            if (!en || sweep_start || timer_expire) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 16'd1;
            end

            if (!en) begin
                overrun_q <= 1'b0;
                pend_q    <= 1'b0;
                stop_q    <= 1'b1;
            end else if (timer_expire && busy_q) begin
                overrun_q <= 1'b1;
                pend_q    <= 1'b1;
            end

            case (state_q)
                IDLE: ;
                SCAN: begin
                    if (stop_q || !en) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (found_d) begin
                        ch_ptr_q <= found_idx_d;
                        snd_q    <= 1'b1;
                        cmd_q    <= 16'(found_idx_d) << 11;
                        state_q  <= SEND1;
                    end else begin
                        sweep_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= WAIT_TMR;
                    end
                end
                SEND1: state_q <= WAIT1;
                WAIT1: begin
                    if (done_rise) begin
                        snd_q   <= 1'b1;
                        state_q <= SEND2;
                    end
                end
                SEND2: state_q <= WAIT2;
                WAIT2: begin
                    if (done_rise) begin
                        result_q[ch_ptr_q] <= spi_resp[11:0];
                        if (stop_q || !en) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            if (ch_ptr_q == CH_W'(NUM_CH - 1)) begin
                                exhausted_q <= 1'b1;
                            end else begin
                                ch_ptr_q <= ch_ptr_q + CH_W'(1);
                            end
                            state_q <= SCAN;
                        end
                    end
                end
                WAIT_TMR: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Sweep start (from IDLE or on period expiry) overrides the per-state updates above.
            if (sweep_start) begin
                mask_q      <= chnl_mask;
                ch_ptr_q    <= '0;
                exhausted_q <= 1'b0;
                stop_q      <= 1'b0;
                pend_q      <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= SCAN;
            end
        end
    end

    assign rd_data    = result_q[rd_chnl];
    assign spi_snd    = snd_q;
    assign spi_cmd    = cmd_q;
    assign sweep_done = sweep_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// Scoreboard bench for a2d_sequencer: expected SPI command frames are queued by the stimulus
// and popped by a monitor on every spi_snd; a small SPI monarch model answers each frame.
module tb_a2d_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  chnl_mask;
    logic [2:0]  rd_chnl;
    logic [11:0] rd_data;
    logic        sweep_done;
    logic        busy;
    logic        overrun;
    logic        spi_snd;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_resp;

    always #5 clk = ~clk;

    a2d_sequencer #(.PERIOD(16'd200), .CH_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .chnl_mask  (chnl_mask),
        .rd_chnl    (rd_chnl),
        .rd_data    (rd_data),
        .sweep_done (sweep_done),
        .busy       (busy),
        .overrun    (overrun),
        .spi_snd    (spi_snd),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_resp   (spi_resp)
    );

    int checks   = 0;
    int failures = 0;
    int snd_count = 0;
    int sd_count  = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // SPI monarch model: done rises lat+1 cycles after snd, held for two cycles.
    int          lat = 4;
    logic        done_force = 1'b0;
    logic        model_done;
    logic        m_act;
    logic        m_second;
    int          m_cnt;
    int          m_hold;
    logic [2:0]  m_ch;
    logic [15:0] resp_tbl [8];

    assign spi_done = model_done | done_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b0;
            m_act      <= 1'b0;
            m_second   <= 1'b0;
            m_cnt      <= 0;
            m_hold     <= 0;
            m_ch       <= 3'd0;
            spi_resp   <= 16'h0000;
        end else if (spi_snd) begin
            m_act      <= 1'b1;
            m_cnt      <= lat;
            m_ch       <= spi_cmd[13:11];
            model_done <= 1'b0;
            m_hold     <= 0;
        end else if (m_act) begin
            if (m_cnt == 0) begin
                m_act      <= 1'b0;
                model_done <= 1'b1;
                m_hold     <= 2;
                spi_resp   <= m_second ? resp_tbl[m_ch] : 16'hDEAD;
                m_second   <= ~m_second;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_hold != 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) model_done <= 1'b0;
        end
    end

    // Monitor: pops one expected frame per spi_snd and counts sweep_done pulses.
    logic [15:0] mon_exp;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (spi_snd) begin
                snd_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_spi_snd", 32'(spi_cmd), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("spi_cmd", 32'(spi_cmd), 32'(mon_exp));
                end
            end
            if (sweep_done) sd_count++;
        end
    end

    task automatic push_pair(input logic [2:0] c);
        exp_q.push_back({2'b00, c, 11'h000});
        exp_q.push_back({2'b00, c, 11'h000});
    endtask

    task automatic wait_sweep_done(input string name, input int bound);
        int n = 0;
        while (!sweep_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sweep_done), 32'h1);
    endtask

    task automatic check_rd(input string name, input logic [2:0] ch, input logic [11:0] exp);
        rd_chnl = ch;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_snd"},    32'(spi_snd),    32'h0);
        check({tag, "_spi_cmd"},    32'(spi_cmd),    32'h0);
        check({tag, "_sweep_done"}, 32'(sweep_done), 32'h0);
        check({tag, "_busy"},       32'(busy),       32'h0);
        check({tag, "_overrun"},    32'(overrun),    32'h0);
        for (int c = 0; c < 8; c++) check_rd({tag, "_rd_data"}, 3'(c), 12'h000);
    endtask

    int n;
    int hits;
    int s0;
    int d0;

    initial begin
        rst_n = 1'b0; en = 1'b0; chnl_mask = 8'h00; rd_chnl = 3'd0;
        for (int c = 0; c < 8; c++) resp_tbl[c] = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: mask 05, two channels, command then read frame each.
        resp_tbl[0] = 16'h0ABC; resp_tbl[2] = 16'h0123;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1000); exp_q.push_back(16'h1000);
        d0 = sd_count;
        chnl_mask = 8'h05; en = 1'b1;
        wait_sweep_done("t1_sweep_done", 400);
        en = 1'b0;
        check("t1_busy_with_done", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        check("t1_sweep_pulses", 32'(sd_count - d0), 32'h1);
        check("t1_cmds_consumed", 32'(exp_q.size()), 32'h0);
        check_rd("t1_rd_ch0", 3'd0, 12'hABC);
        check_rd("t1_rd_ch2", 3'd2, 12'h123);
        check_rd("t1_rd_ch1", 3'd1, 12'h000);
        @(negedge clk);

        // Test 2: empty mask completes without SPI traffic.
        s0 = snd_count;
        chnl_mask = 8'h00; en = 1'b1;
        for (n = 0; n < 3 && !sweep_done; n++) @(negedge clk);
        check("t2_sweep_done_within_3", 32'(sweep_done), 32'h1);
        check("t2_busy_low", 32'(busy), 32'h0);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_no_snd", 32'(snd_count - s0), 32'h0);

        // Test 4: en falls during ch3 WAIT1; mask change mid-sweep ignored.
        resp_tbl[0] = 16'h1111; resp_tbl[1] = 16'h2222;
        resp_tbl[2] = 16'h3456; resp_tbl[3] = 16'hF3C5;
        for (int c = 0; c < 4; c++) push_pair(3'(c));
        d0 = sd_count; s0 = snd_count;
        chnl_mask = 8'hFF; en = 1'b1;
        @(negedge clk);
        chnl_mask = 8'h00;
        n = 0;
        while (!(spi_snd && spi_cmd == 16'h1800) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t4_ch3_send1_seen", 32'(spi_snd), 32'h1);
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_busy_dropped", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        check("t4_snd_total", 32'(snd_count - s0), 32'h8);
        check("t4_cmds_consumed", 32'(exp_q.size()), 32'h0);
        check("t4_no_sweep_done", 32'(sd_count - d0), 32'h0);
        check_rd("t4_rd_ch3", 3'd3, 12'h3C5);
        check_rd("t4_rd_ch2", 3'd2, 12'h456);
        check_rd("t4_rd_ch0", 3'd0, 12'h111);

        // Test 3: slow SPI, sweep longer than the period -> overrun and back-to-back sweeps.
        lat = 40;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 8; c++) push_pair(3'(c));
        chnl_mask = 8'hFF; en = 1'b1;
        n = 0;
        while (!overrun && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t3_overrun_set", 32'(overrun), 32'h1);
        check("t3_busy_at_overrun", 32'(busy), 32'h1);
        wait_sweep_done("t3_sweep1_done", 1500);
        check("t3_busy_low_at_done1", 32'(busy), 32'h0);
        @(negedge clk);
        check("t3_back_to_back1", 32'(busy), 32'h1);
        wait_sweep_done("t3_sweep2_done", 1500);
        @(negedge clk);
        check("t3_back_to_back2", 32'(busy), 32'h1);
        check("t3_overrun_sticky", 32'(overrun), 32'h1);
        en = 1'b0;
        @(negedge clk);
        check("t3_overrun_cleared", 32'(overrun), 32'h0);
        check("t3_busy_cleared", 32'(busy), 32'h0);
        repeat (60) @(negedge clk);
        exp_q.delete();
        lat = 4;

        // Test 5: reset during ch1 WAIT2, then a clean sweep.
        resp_tbl[0] = 16'h05A5; resp_tbl[1] = 16'h0777;
        push_pair(3'd0); push_pair(3'd1);
        chnl_mask = 8'h03; en = 1'b1;
        n = 0; hits = 0;
        while (hits < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (spi_snd && spi_cmd == 16'h0800) hits++;
        end
        check("t5_ch1_send2_seen", 32'(hits), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_cmds_consumed", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        resp_tbl[0] = 16'h0246;
        push_pair(3'd0);
        chnl_mask = 8'h01; en = 1'b1;
        wait_sweep_done("t5_restart_done", 200);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_restart_cmds", 32'(exp_q.size()), 32'h0);
        check_rd("t5_rd_ch0", 3'd0, 12'h246);
        check_rd("t5_rd_ch1", 3'd1, 12'h000);

        // Test 6: spi_done held high across SEND1->WAIT1 must not count as completion.
        lat = 10;
        resp_tbl[2] = 16'h09E1;
        push_pair(3'd2);
        done_force = 1'b1;
        chnl_mask = 8'h04; en = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (spi_snd) hits++;
        end
        check("t6_single_snd_while_stale", 32'(hits), 32'h1);
        check("t6_busy_waiting", 32'(busy), 32'h1);
        done_force = 1'b0;
        wait_sweep_done("t6_sweep_done", 200);
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_cmds_consumed", 32'(exp_q.size()), 32'h0);
        check_rd("t6_rd_ch2", 3'd2, 12'h9E1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
